uart_rx_cfg: RTL



---
 rtl/uart_rx_cfg.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver.
// Oversampled by rx_clk with a per-frame prescale, 5..DATA_WIDTH data bits,
// optional parity, one or two stop bits, 3-sample majority voting, break
// detection and a valid/ready output register with overrun reporting.
module uart_rx_cfg #(
    parameter int unsigned DATA_WIDTH     = 9,
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned LEN_WIDTH      = 4
) (
    input  logic                      rx_clk,
    input  logic                      rst_n,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [LEN_WIDTH-1:0]      data_len,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      two_stop,
    input  logic                      data_ready,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      stop_error,
    output logic                      break_det,
    output logic                      overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_MIN = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE        = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] P_TWO        = PRESCALE_WIDTH'(2);
    localparam logic [LEN_WIDTH-1:0]      LEN_MIN      = LEN_WIDTH'(5);
    localparam logic [LEN_WIDTH-1:0]      LEN_MAX      = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0]      L_ONE        = LEN_WIDTH'(1);

    state_t state;
    state_t state_next;

    // Sanitised live configuration and the copy frozen for the current frame
    logic [PRESCALE_WIDTH-1:0] prescale_sane;
    logic [LEN_WIDTH-1:0]      len_sane;
    logic [PRESCALE_WIDTH-1:0] cfg_prescale;
    logic [LEN_WIDTH-1:0]      cfg_len;
    logic                      cfg_parity_enable;
    logic                      cfg_parity_type;
    logic                      cfg_two_stop;

    // Bit timing
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half_bit;
    logic [PRESCALE_WIDTH-1:0] sample_lo;
    logic [PRESCALE_WIDTH-1:0] sample_hi;
    logic [PRESCALE_WIDTH-1:0] done_point;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [LEN_WIDTH-1:0]      bit_cnt;

    // Sampling and frame contents
    logic [2:0]            samples;
    logic                  majority;
    logic [DATA_WIDTH-1:0] shift_data;
    logic                  parity_bit;
    logic                  stop_err_acc;
    logic                  stop_idx;

    // Control strobes
    logic in_frame;
    logic sample_now;
    logic bit_end;
    logic at_done;
    logic last_stop;
    logic start_det;
    logic frame_done;
    logic final_stop_err;
    logic final_parity_err;
    logic final_break;
    logic load;

    // Clamp prescale to an even value >= 8 and data length to 5..DATA_WIDTH
    always_comb begin
        if (prescale < PRESCALE_MIN) begin
            prescale_sane = PRESCALE_MIN;
        end else begin
            prescale_sane = {prescale[PRESCALE_WIDTH-1:1], 1'b0};
        end

        if (data_len < LEN_MIN) begin
            len_sane = LEN_MIN;
        end else if (data_len > LEN_MAX) begin
            len_sane = LEN_MAX;
        end else begin
            len_sane = data_len;
        end
    end

    // Sample points, bit boundary and majority vote derived from the frozen prescale
    always_comb begin
        half_bit   = cfg_prescale >> 1;
        sample_lo  = half_bit - P_ONE;
        sample_hi  = half_bit + P_ONE;
        done_point = half_bit + P_TWO;
        last_edge  = cfg_prescale - P_ONE;

        in_frame   = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
        sample_now = in_frame && (edge_cnt >= sample_lo) && (edge_cnt <= sample_hi);
        bit_end    = (edge_cnt == last_edge);
        at_done    = (edge_cnt == done_point);
        last_stop  = (stop_idx == cfg_two_stop);

        majority   = (samples[0] & samples[1]) |
                     (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

        final_stop_err   = stop_err_acc | ~majority;
        final_parity_err = cfg_parity_enable &
                           (((^shift_data) ^ parity_bit) != cfg_parity_type);
        final_break      = (shift_data == '0) &
                           ~(cfg_parity_enable & parity_bit) &
                           final_stop_err;
    end

    // State register
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and frame strobes
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == cfg_len - L_ONE)) begin
                    state_next = cfg_parity_enable ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // The last stop bit finishes early, just after its samples, so a
                // start edge arriving slightly early is still caught in IDLE.
                if (last_stop && at_done) begin
                    frame_done = 1'b1;
                    state_next = final_stop_err ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (rx_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-frame datapath: config capture, bit timing, sampling and bit collection
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_prescale      <= '0;
            cfg_len           <= '0;
            cfg_parity_enable <= 1'b0;
            cfg_parity_type   <= 1'b0;
            cfg_two_stop      <= 1'b0;
            edge_cnt          <= '0;
            bit_cnt           <= '0;
            samples           <= '0;
            shift_data        <= '0;
            parity_bit        <= 1'b0;
            stop_err_acc      <= 1'b0;
            stop_idx          <= 1'b0;
        end else if (start_det) begin
            cfg_prescale      <= prescale_sane;
            cfg_len           <= len_sane;
            cfg_parity_enable <= parity_enable;
            cfg_parity_type   <= parity_type;
            cfg_two_stop      <= two_stop;
            edge_cnt          <= '0;
            bit_cnt           <= '0;
            samples           <= '0;
            shift_data        <= '0;
            parity_bit        <= 1'b0;
            stop_err_acc      <= 1'b0;
            stop_idx          <= 1'b0;
        end else if (in_frame) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + P_ONE;
            if (sample_now) begin
                samples <= {samples[1:0], rx_in};
            end
            if (bit_end) begin
                case (state)
                    DATA: begin
                        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                            if (i == 32'(bit_cnt)) begin
                                shift_data[i] <= majority;
                            end
                        end
                        bit_cnt <= bit_cnt + L_ONE;
                    end
                    PARITY: begin
                        parity_bit <= majority;
                    end
                    STOP: begin
                        // Only the first of two stop bits reaches its full bit time
                        stop_err_acc <= stop_err_acc | ~majority;
                        stop_idx     <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            edge_cnt <= '0;
        end
    end

    assign load = frame_done && (!data_valid || data_ready);

    // Output register: load on frame complete if free, otherwise flag overrun
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                p_data       <= shift_data;
                parity_error <= final_parity_err;
                stop_error   <= final_stop_err;
                break_det    <= final_break;
                data_valid   <= 1'b1;
            end else begin
                if (frame_done) begin
                    overrun <= 1'b1;
                end
                if (data_valid && data_ready) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule
